// File: rtl/sfifo_wconv_pkg.sv
// sfifo_wconv_pkg: flag indices and sizing helpers shared by the width-converting FIFO.
package sfifo_wconv_pkg;

  // Bit positions of the status flags inside the registered flag vector
  localparam int unsigned FLAG_FULL   = 0;
  localparam int unsigned FLAG_EMPTY  = 1;
  localparam int unsigned FLAG_AFULL  = 2;
  localparam int unsigned FLAG_AEMPTY = 3;
  localparam int unsigned FLAG_FWM    = 4;
  localparam int unsigned FLAG_EWM    = 5;
  localparam int unsigned FLAG_OVR    = 6;
  localparam int unsigned FLAG_UNR    = 7;
  localparam int unsigned NUM_FLAGS   = 8;

  // Flag state after a flush: only the "emptiness" flags are set
  localparam logic [NUM_FLAGS-1:0] FLAGS_FLUSH =
    NUM_FLAGS'((1 << FLAG_EMPTY) | (1 << FLAG_AEMPTY) | (1 << FLAG_EWM));

  // Narrow unit width shared by both ports
  function automatic int unsigned min_width(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Port widths must be whole multiples of each other with ratio 1, 2 or 4
  function automatic logic ratio_ok(input int unsigned w0, input int unsigned w1);
    int unsigned wide;
    int unsigned narrow;
    wide   = (w0 > w1) ? w0 : w1;
    narrow = (w0 > w1) ? w1 : w0;
    if (narrow == 0) return 1'b0;
    if ((wide % narrow) != 0) return 1'b0;
    return ((wide / narrow) == 1) || ((wide / narrow) == 2) || ((wide / narrow) == 4);
  endfunction

  // Bits needed to hold an occupancy count from 0 up to and including cap
  function automatic int unsigned unit_cnt_width(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/sfifo_wconv_ram.sv
// sfifo_wconv_ram: simple dual-port RAM of narrow units; the write port stores
// WR_UNITS consecutive units and the read port fetches RD_UNITS consecutive units.
// Macro SFIFO_WCONV_FWFT_EN turns the registered read into a combinational read.
module sfifo_wconv_ram #(
  parameter int unsigned UNIT_W   = 36,
  parameter int unsigned WR_UNITS = 1,
  parameter int unsigned RD_UNITS = 1,
  parameter int unsigned AW       = 10
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [UNIT_W*WR_UNITS-1:0]   wdata,
  input  logic                         re,
  input  logic [AW-1:0]                raddr,
  input  logic                         rclr,
  output logic [UNIT_W*RD_UNITS-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [UNIT_W-1:0] mem [DEPTH];

  // Write port: little-endian split of the write word into consecutive units
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < WR_UNITS; i++) begin
        mem[waddr + AW'(i)] <= wdata[i*UNIT_W +: UNIT_W];
      end
    end
  end

`ifdef SFIFO_WCONV_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, re, rclr};

  // Read port: head units are always visible, no read register
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < RD_UNITS; i++) begin
      rdata[i*UNIT_W +: UNIT_W] = mem[raddr + AW'(i)];
    end
  end
`else
  // Read port: registered read, holds its value until the next accepted read
  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      for (int unsigned i = 0; i < RD_UNITS; i++) begin
        rdata[i*UNIT_W +: UNIT_W] <= mem[raddr + AW'(i)];
      end
    end
  end
`endif

endmodule

// File: rtl/sfifo_wconv.sv
// sfifo_wconv: single-clock FIFO with independent write and read port widths
// (ratio 1, 2 or 4). Storage, pointers and occupancy are kept in narrow units.
// Optional macro SFIFO_WCONV_FWFT_EN selects first-word-fall-through reads.
module sfifo_wconv
  import sfifo_wconv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH0         = 36,
  parameter int unsigned DATA_WIDTH1         = 36,
  parameter int unsigned ADDR_WIDTH0         = 10,
  parameter int unsigned ALMOST_FULL_OFFSET  = 4,
  parameter int unsigned ALMOST_EMPTY_OFFSET = 4,
  parameter int unsigned FULL_WM  =
    ((1 << ADDR_WIDTH0) * (DATA_WIDTH0 / min_width(DATA_WIDTH0, DATA_WIDTH1)) * 3) / 4,
  parameter int unsigned EMPTY_WM =
    ((1 << ADDR_WIDTH0) * (DATA_WIDTH0 / min_width(DATA_WIDTH0, DATA_WIDTH1))) / 4
) (
  input  logic                   clock0,
  input  logic                   Sync_Flush,
  input  logic [DATA_WIDTH0-1:0] DIN,
  input  logic                   PUSH,
  input  logic                   POP,
  output logic [DATA_WIDTH1-1:0] DOUT,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Almost_Full,
  output logic                   Almost_Empty,
  output logic                   Full_Watermark,
  output logic                   Empty_Watermark,
  output logic                   Overrun_Error,
  output logic                   Underrun_Error
);

  localparam int unsigned N  = min_width(DATA_WIDTH0, DATA_WIDTH1);
  localparam int unsigned R0 = DATA_WIDTH0 / N;
  localparam int unsigned R1 = DATA_WIDTH1 / N;
  localparam int unsigned C  = (1 << ADDR_WIDTH0) * R0;
  localparam int unsigned PW = $clog2(C);
  localparam int unsigned CW = unit_cnt_width(C);

  if (!ratio_ok(DATA_WIDTH0, DATA_WIDTH1)) begin : g_bad_ratio
    $error("sfifo_wconv: DATA_WIDTH0/DATA_WIDTH1 ratio must be 1, 2 or 4");
  end

  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic                   push_ok, pop_ok;
  logic [31:0]            cnt_n, free_n;
  logic [DATA_WIDTH1-1:0] ram_rdata;

  // Next pointers, occupancy and flags; legality uses the pre-edge flags
  always_comb begin
    push_ok = PUSH & ~flags_q[FLAG_FULL];
    pop_ok  = POP  & ~flags_q[FLAG_EMPTY];
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    flags_d = '0;
    if (push_ok) begin
      wptr_d = wptr_q + PW'(R0);
      cnt_d  = cnt_d + CW'(R0);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PW'(R1);
      cnt_d  = cnt_d - CW'(R1);
    end
    cnt_n  = 32'(cnt_d);
    free_n = C - cnt_n;
    flags_d[FLAG_FULL]   = free_n < R0;
    flags_d[FLAG_EMPTY]  = cnt_n < R1;
    flags_d[FLAG_AFULL]  = free_n <= ALMOST_FULL_OFFSET;
    flags_d[FLAG_AEMPTY] = cnt_n <= ALMOST_EMPTY_OFFSET;
    flags_d[FLAG_FWM]    = cnt_n >= FULL_WM;
    flags_d[FLAG_EWM]    = cnt_n <= EMPTY_WM;
    flags_d[FLAG_OVR]    = PUSH & flags_q[FLAG_FULL];
    flags_d[FLAG_UNR]    = POP & flags_q[FLAG_EMPTY];
  end

  // State registers; flush wins over any request in the same cycle
  always_ff @(posedge clock0) begin
    if (Sync_Flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      flags_q <= FLAGS_FLUSH;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  sfifo_wconv_ram #(
    .UNIT_W   (N),
    .WR_UNITS (R0),
    .RD_UNITS (R1),
    .AW       (PW)
  ) u_ram (
    .clk   (clock0),
    .we    (push_ok & ~Sync_Flush),
    .waddr (wptr_q),
    .wdata (DIN),
    .re    (pop_ok & ~Sync_Flush),
    .raddr (rptr_q),
    .rclr  (Sync_Flush),
    .rdata (ram_rdata)
  );

`ifdef SFIFO_WCONV_FWFT_EN
  assign DOUT = flags_q[FLAG_EMPTY] ? '0 : ram_rdata;
`else
  assign DOUT = ram_rdata;
`endif

  assign Full            = flags_q[FLAG_FULL];
  assign Empty           = flags_q[FLAG_EMPTY];
  assign Almost_Full     = flags_q[FLAG_AFULL];
  assign Almost_Empty    = flags_q[FLAG_AEMPTY];
  assign Full_Watermark  = flags_q[FLAG_FWM];
  assign Empty_Watermark = flags_q[FLAG_EWM];
  assign Overrun_Error   = flags_q[FLAG_OVR];
  assign Underrun_Error  = flags_q[FLAG_UNR];

endmodule

// File: tb/tb_sfifo_wconv.sv
// tb_sfifo_wconv: directed checks of three FIFO instances (36/36 depth 1024,
// 36->18 and 18->36 with small depth). Status vectors are ordered
// {UNR, OVR, EWM, FWM, AE, AF, EMPTY, FULL}.
module tb_sfifo_wconv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        fl0, push0, pop0;
  logic [35:0] din0, dout0;
  logic [7:0]  st0;
  logic        fl1, push1, pop1;
  logic [35:0] din1;
  logic [17:0] dout1;
  logic [7:0]  st1;
  logic        fl2, push2, pop2;
  logic [17:0] din2;
  logic [35:0] dout2;
  logic [7:0]  st2;

  int n_pass = 0;
  int n_chk  = 0;
  logic [35:0] sb[$];
  logic [35:0] exp_w;
  logic [35:0] w1;

  sfifo_wconv #(.DATA_WIDTH0(36), .DATA_WIDTH1(36), .ADDR_WIDTH0(10)) u0 (
    .clock0(clk), .Sync_Flush(fl0), .DIN(din0), .PUSH(push0), .POP(pop0), .DOUT(dout0),
    .Full(st0[0]), .Empty(st0[1]), .Almost_Full(st0[2]), .Almost_Empty(st0[3]),
    .Full_Watermark(st0[4]), .Empty_Watermark(st0[5]),
    .Overrun_Error(st0[6]), .Underrun_Error(st0[7]));

  sfifo_wconv #(.DATA_WIDTH0(36), .DATA_WIDTH1(18), .ADDR_WIDTH0(4)) u1 (
    .clock0(clk), .Sync_Flush(fl1), .DIN(din1), .PUSH(push1), .POP(pop1), .DOUT(dout1),
    .Full(st1[0]), .Empty(st1[1]), .Almost_Full(st1[2]), .Almost_Empty(st1[3]),
    .Full_Watermark(st1[4]), .Empty_Watermark(st1[5]),
    .Overrun_Error(st1[6]), .Underrun_Error(st1[7]));

  sfifo_wconv #(.DATA_WIDTH0(18), .DATA_WIDTH1(36), .ADDR_WIDTH0(4)) u2 (
    .clock0(clk), .Sync_Flush(fl2), .DIN(din2), .PUSH(push2), .POP(pop2), .DOUT(dout2),
    .Full(st2[0]), .Empty(st2[1]), .Almost_Full(st2[2]), .Almost_Empty(st2[3]),
    .Full_Watermark(st2[4]), .Empty_Watermark(st2[5]),
    .Overrun_Error(st2[6]), .Underrun_Error(st2[7]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic chkf(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  function automatic logic [35:0] pat(input int a);
    return 36'(a) | (36'(a) << 20) | 36'h0_0005_5000;
  endfunction

  initial begin
    fl0 = 1'b1; push0 = 1'b0; pop0 = 1'b0; din0 = '0;
    fl1 = 1'b1; push1 = 1'b0; pop1 = 1'b0; din1 = '0;
    fl2 = 1'b1; push2 = 1'b0; pop2 = 1'b0; din2 = '0;
    tick();
    tick();
    chk("rst_st0", 36'(st0), 36'h2A);
    chk("rst_dout0", dout0, 36'h0);
    chk("rst_st1", 36'(st1), 36'h2A);
    chk("rst_st2", 36'(st2), 36'h2A);
    fl0 = 1'b0; fl1 = 1'b0; fl2 = 1'b0;

    // Fill the 36/36 FIFO to its 1024-word capacity
    push0 = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      din0 = pat(a);
      sb.push_back(pat(a));
      tick();
      if (a == 0)    chkf("empty_after_first", st0[1], 1'b0);
      if (a == 0)    chkf("ae_at_1", st0[3], 1'b1);
      if (a == 4)    chkf("ae_at_5", st0[3], 1'b0);
      if (a == 766)  chkf("fwm_at_767", st0[4], 1'b0);
      if (a == 767)  chkf("fwm_at_768", st0[4], 1'b1);
      if (a == 1018) chkf("af_at_1019", st0[2], 1'b0);
      if (a == 1019) chkf("af_at_1020", st0[2], 1'b1);
      if (a == 1022) chkf("full_at_1023", st0[0], 1'b0);
      if (a == 1023) chkf("full_at_1024", st0[0], 1'b1);
    end

    // Push while full: dropped, one-cycle overrun pulse
    din0 = 36'hF_FFFF_FFFF;
    tick();
    chkf("ovr_pulse", st0[6], 1'b1);
    chkf("full_held", st0[0], 1'b1);
    push0 = 1'b0;
    tick();
    chkf("ovr_clear", st0[6], 1'b0);
    chkf("full_still", st0[0], 1'b1);

    // Drain in order
    pop0 = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      exp_w = sb.pop_front();
      tick();
      chk("drain_data", dout0, exp_w);
      if (k == 0)    chkf("full_clear", st0[0], 1'b0);
      if (k == 766)  chkf("ewm_at_257", st0[5], 1'b0);
      if (k == 767)  chkf("ewm_at_256", st0[5], 1'b1);
      if (k == 1022) chkf("empty_at_1", st0[1], 1'b0);
      if (k == 1023) chkf("empty_at_0", st0[1], 1'b1);
    end

    // Pop while empty: ignored, one-cycle underrun pulse, DOUT held
    tick();
    chkf("unr_pulse", st0[7], 1'b1);
    chk("dout_held", dout0, pat(1023));
    pop0 = 1'b0;
    tick();
    chkf("unr_clear", st0[7], 1'b0);
    chkf("empty_still", st0[1], 1'b1);

    // Bring occupancy to 512, then push+pop every cycle across many wraps
    push0 = 1'b1;
    for (int k = 0; k < 512; k++) begin
      din0 = 36'h9_0000_0000 | 36'(k);
      sb.push_back(din0);
      tick();
    end
    pop0 = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      din0 = 36'hA_0000_0000 | 36'(k);
      sb.push_back(din0);
      exp_w = sb.pop_front();
      tick();
      chk("stream_data", dout0, exp_w);
      chk("stream_st", 36'(st0), 36'h0);
    end

    // Raise occupancy to 700 then flush with requests asserted
    pop0 = 1'b0;
    for (int k = 0; k < 188; k++) begin
      din0 = 36'hB_0000_0000 | 36'(k);
      tick();
    end
    sb.delete();
    fl0 = 1'b1; push0 = 1'b1; pop0 = 1'b1; din0 = 36'h0_0000_0777;
    tick();
    fl0 = 1'b0; push0 = 1'b0; pop0 = 1'b0;
    chk("flush_st", 36'(st0), 36'h2A);
    chk("flush_dout", dout0, 36'h0);
    din0 = 36'hC_AFE0_0001;
    push0 = 1'b1;
    tick();
    push0 = 1'b0;
    din0 = 36'h0;
    chkf("post_flush_nonempty", st0[1], 1'b0);
    pop0 = 1'b1;
    tick();
    pop0 = 1'b0;
    chk("post_flush_first", dout0, 36'hC_AFE0_0001);
    chkf("post_flush_empty", st0[1], 1'b1);

    // 36-bit write, 18-bit read: low half first
    w1 = 36'h1_2345_6789;
    din1 = w1;
    push1 = 1'b1;
    tick();
    push1 = 1'b0;
    chkf("w2n_nonempty", st1[1], 1'b0);
    pop1 = 1'b1;
    tick();
    chk("w2n_lo", 36'(dout1), 36'(w1[17:0]));
    chkf("w2n_empty_mid", st1[1], 1'b0);
    tick();
    pop1 = 1'b0;
    chk("w2n_hi", 36'(dout1), 36'(w1[35:18]));
    chkf("w2n_empty_end", st1[1], 1'b1);

    // 18-bit write, 36-bit read: needs two pushes before a read is legal
    din2 = 18'h00001;
    push2 = 1'b1;
    tick();
    chkf("n2w_empty_half", st2[1], 1'b1);
    din2 = 18'h00002;
    tick();
    push2 = 1'b0;
    chkf("n2w_nonempty", st2[1], 1'b0);
    pop2 = 1'b1;
    tick();
    pop2 = 1'b0;
    chk("n2w_data", dout2, 36'h0_0008_0001);
    chkf("n2w_empty_end", st2[1], 1'b1);

    // One narrow unit stored is still empty for the wide reader
    din2 = 18'h00003;
    push2 = 1'b1;
    tick();
    push2 = 1'b0;
    pop2 = 1'b1;
    tick();
    pop2 = 1'b0;
    chkf("n2w_unr", st2[7], 1'b1);
    chk("n2w_dout_held", dout2, 36'h0_0008_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
